// File: rtl/div_pkg.sv
// Shared types and constants for the repeated-subtraction divider controller.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } div_state_t;

  localparam logic        MUX_LOAD     = 1'b0;
  localparam logic        MUX_SUB      = 1'b1;
  localparam logic [31:0] DEF_MAX_ITER = 32'hFFFF_FFFF;

  // The datapath compares signed, so only 0..2^31-1 operands (and B != 0) are usable.
  function automatic logic operand_illegal(input logic [31:0] a, input logic [31:0] b);
    return (b == 32'd0) || b[31] || a[31];
  endfunction

endpackage

// File: rtl/div_if.sv
// Requester-side handshake of the divider: start/operands in, busy/done/status out.
interface div_if;
  logic        start;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        done;
  logic        arg_err;
  logic        ovf_err;

  modport master (
    output start, A, B,
    input  busy, done, arg_err, ovf_err
  );

  modport slave (
    input  start, A, B,
    output busy, done, arg_err, ovf_err
  );
endinterface

// File: rtl/div_ctrl.sv
// Control FSM for the repeated-subtraction divider datapath: sequences load/subtract
// steps, watches b_less for completion and aborts through an iteration watchdog.
module div_ctrl
  import div_pkg::*;
#(
  parameter int unsigned       ITER_W   = 32,
  parameter logic [ITER_W-1:0] MAX_ITER = ITER_W'(DEF_MAX_ITER)
) (
  input  logic clk,
  input  logic rst_n,
  div_if.slave req,
  input  logic b_less,
  output logic ld,
  output logic mux
);

  div_state_t        state_r;
  logic [ITER_W-1:0] iter_r;
  logic              arg_err_r;
  logic              ovf_err_r;
  logic              at_limit_s;

  assign at_limit_s = (iter_r == MAX_ITER);

  // Sequencing, iteration count and sticky error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      iter_r    <= {ITER_W{1'b0}};
      arg_err_r <= 1'b0;
      ovf_err_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req.start) begin
            ovf_err_r <= 1'b0;
            if (operand_illegal(req.A, req.B)) begin
              arg_err_r <= 1'b1;
              state_r   <= DONE;
            end else begin
              arg_err_r <= 1'b0;
              state_r   <= LOAD;
            end
          end
        end
        LOAD: begin
          iter_r  <= {ITER_W{1'b0}};
          state_r <= RUN;
        end
        RUN: begin
          // Completion wins over the watchdog when both hold in the same cycle.
          if (b_less) begin
            state_r <= DONE;
          end else if (at_limit_s) begin
            ovf_err_r <= 1'b1;
            state_r   <= DONE;
          end else begin
            iter_r <= iter_r + ITER_W'(1'b1);
          end
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Datapath strobes: Moore in LOAD, Mealy on b_less/watchdog in RUN, idle elsewhere.
  always_comb begin
    ld  = 1'b0;
    mux = MUX_LOAD;
    case (state_r)
      LOAD: begin
        ld  = 1'b1;
        mux = MUX_LOAD;
      end
      RUN: begin
        if (!b_less && !at_limit_s) begin
          ld  = 1'b1;
          mux = MUX_SUB;
        end else begin
          ld  = 1'b0;
          mux = MUX_LOAD;
        end
      end
      default: begin
        ld  = 1'b0;
        mux = MUX_LOAD;
      end
    endcase
  end

  assign req.busy    = (state_r == LOAD) || (state_r == RUN);
  assign req.done    = (state_r == DONE);
  assign req.arg_err = arg_err_r;
  assign req.ovf_err = ovf_err_r;

endmodule

// File: tb/tb_div_ctrl.sv
// Bench for div_ctrl: two instances (default and MAX_ITER=10) each driving a behavioural
// model of the subtraction datapath; expected results go through a scoreboard queue.
module tb_div_ctrl;
  import div_pkg::*;

  typedef struct {
    int          done_cyc;
    int          lds;
    logic [31:0] q;
    logic [31:0] r;
    logic        ae;
    logic        oe;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  div_if m_if ();
  div_if w_if ();
  logic b_less_m, ld_m, mux_m;
  logic b_less_w, ld_w, mux_w;
  logic [31:0] r_m, q_m, r_w, q_w;

  div_ctrl dut (
    .clk(clk), .rst_n(rst_n), .req(m_if.slave),
    .b_less(b_less_m), .ld(ld_m), .mux(mux_m)
  );

  div_ctrl #(.ITER_W(32), .MAX_ITER(32'd10)) dut_wd (
    .clk(clk), .rst_n(rst_n), .req(w_if.slave),
    .b_less(b_less_w), .ld(ld_w), .mux(mux_w)
  );

  // Datapath models (no reset, like the real datapath).
  always_ff @(posedge clk) begin
    if (ld_m) begin
      if (mux_m == MUX_LOAD) begin r_m <= m_if.A; q_m <= 32'd0; end
      else begin r_m <= r_m - m_if.B; q_m <= q_m + 32'd1; end
    end
  end
  always_ff @(posedge clk) begin
    if (ld_w) begin
      if (mux_w == MUX_LOAD) begin r_w <= w_if.A; q_w <= 32'd0; end
      else begin r_w <= r_w - w_if.B; q_w <= q_w + 32'd1; end
    end
  end
  assign b_less_m = $signed(r_m) < $signed(m_if.B);
  assign b_less_w = $signed(r_w) < $signed(w_if.B);

  int   n_pass = 0;
  int   n_total = 0;
  exp_t sb[$];

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input longint maxi);
    exp_t   e;
    longint qq;
    e.ae = 1'b0; e.oe = 1'b0; e.q = 32'd0; e.r = 32'd0;
    if (b == 32'd0 || $signed(b) < 0 || $signed(a) < 0) begin
      e.ae = 1'b1; e.done_cyc = 1; e.lds = 0;
    end else begin
      qq = longint'(a) / longint'(b);
      if (qq > maxi) begin
        e.oe = 1'b1;
        e.q = 32'(maxi);
        e.r = 32'(longint'(a) - maxi * longint'(b));
        e.done_cyc = int'(maxi) + 3;
        e.lds = int'(maxi) + 1;
      end else begin
        e.q = 32'(qq);
        e.r = a % b;
        e.done_cyc = int'(qq) + 3;
        e.lds = int'(qq) + 1;
      end
    end
    return e;
  endfunction

  // Drives one request on the chosen instance and records what the DUT did (no checking).
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit wd,
                        input int p1, input int p2,
                        output int done_cyc, output int done_cnt, output int busy_bad,
                        output int ld_cnt, output int load_cnt,
                        output logic [31:0] q, output logic [31:0] r,
                        output logic ae, output logic oe);
    logic c_busy, c_done, c_ld, c_mux;
    done_cyc = -1; done_cnt = 0; busy_bad = 0; ld_cnt = 0; load_cnt = 0;
    q = 32'hDEAD_BEEF; r = 32'hDEAD_BEEF;
    @(negedge clk);
    if (wd) begin w_if.A = a; w_if.B = b; w_if.start = 1'b1; end
    else begin m_if.A = a; m_if.B = b; m_if.start = 1'b1; end
    @(posedge clk);
    for (int k = 1; k <= 3000; k++) begin
      @(negedge clk);
      if (wd) w_if.start = (k == p1) || (k == p2);
      else    m_if.start = (k == p1) || (k == p2);
      c_busy = wd ? w_if.busy : m_if.busy;
      c_done = wd ? w_if.done : m_if.done;
      c_ld   = wd ? ld_w : ld_m;
      c_mux  = wd ? mux_w : mux_m;
      if (c_done) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc = k;
          q = wd ? q_w : q_m;
          r = wd ? r_w : r_m;
        end
      end
      if (c_busy !== (done_cyc < 0)) busy_bad++;
      if (c_ld) ld_cnt++;
      if (c_ld && c_mux == MUX_LOAD) load_cnt++;
      if (done_cyc >= 0 && k >= done_cyc + 3) break;
    end
    ae = wd ? w_if.arg_err : m_if.arg_err;
    oe = wd ? w_if.ovf_err : m_if.ovf_err;
    m_if.start = 1'b0;
    w_if.start = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_total++;
    if ({m_if.busy, m_if.done, m_if.arg_err, m_if.ovf_err, ld_m, mux_m} !== 6'b0) begin
      $display("FAIL reset_outputs: got %b expected 000000",
               {m_if.busy, m_if.done, m_if.arg_err, m_if.ovf_err, ld_m, mux_m});
    end else n_pass++;
    m_if.start = 1'b1; w_if.start = 1'b1;
    repeat (2) @(negedge clk);
    n_total++;
    if ({w_if.busy, w_if.done, ld_w, m_if.busy, ld_m} !== 5'b0) begin
      $display("FAIL reset_held: got %b expected 00000", {w_if.busy, w_if.done, ld_w, m_if.busy, ld_m});
    end else n_pass++;
    m_if.start = 1'b0; w_if.start = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_total++;
    if ({m_if.busy, m_if.done, ld_m} !== 3'b0) begin
      $display("FAIL reset_idle: got %b expected 000", {m_if.busy, m_if.done, ld_m});
    end else n_pass++;
  endtask

  task automatic test_basic();
    int dc, dn, bb, lc, lo; logic [31:0] q, r; logic ae, oe; exp_t e;
    sb.push_back(model(32'd100, 32'd7, longint'(DEF_MAX_ITER)));
    run_op(32'd100, 32'd7, 1'b0, 0, 0, dc, dn, bb, lc, lo, q, r, ae, oe);
    e = sb.pop_front();
    n_total++; if (dc !== e.done_cyc) $display("FAIL basic_done_cycle: got %0d expected %0d", dc, e.done_cyc); else n_pass++;
    n_total++; if (bb !== 0) $display("FAIL basic_busy: got %0d bad cycles expected 0", bb); else n_pass++;
    n_total++; if (q !== e.q || r !== e.r) $display("FAIL basic_result: got q=%0d r=%0d expected q=%0d r=%0d", q, r, e.q, e.r); else n_pass++;
    n_total++; if ({ae, oe} !== {e.ae, e.oe}) $display("FAIL basic_errors: got %b expected %b", {ae, oe}, {e.ae, e.oe}); else n_pass++;
    n_total++; if (lc !== e.lds) $display("FAIL basic_ld_count: got %0d expected %0d", lc, e.lds); else n_pass++;
  endtask

  task automatic test_short();
    int dc, dn, bb, lc, lo; logic [31:0] q, r; logic ae, oe; exp_t e;
    sb.push_back(model(32'd5, 32'd9, longint'(DEF_MAX_ITER)));
    run_op(32'd5, 32'd9, 1'b0, 0, 0, dc, dn, bb, lc, lo, q, r, ae, oe);
    e = sb.pop_front();
    n_total++; if (dc !== e.done_cyc) $display("FAIL short_done_cycle: got %0d expected %0d", dc, e.done_cyc); else n_pass++;
    n_total++; if (q !== e.q || r !== e.r) $display("FAIL short_result: got q=%0d r=%0d expected q=%0d r=%0d", q, r, e.q, e.r); else n_pass++;
    n_total++; if (lc !== 1 || lo !== 1) $display("FAIL short_single_load: got ld=%0d load=%0d expected 1/1", lc, lo); else n_pass++;
    n_total++; if ({ae, oe} !== 2'b00) $display("FAIL short_errors_cleared: got %b expected 00", {ae, oe}); else n_pass++;
  endtask

  task automatic test_arg_err();
    logic [31:0] av [3] = '{32'd10, 32'h8000_0000, 32'd10};
    logic [31:0] bv [3] = '{32'd0, 32'd3, 32'h8000_0001};
    int dc, dn, bb, lc, lo; logic [31:0] q, r; logic ae, oe; exp_t e;
    for (int i = 0; i < 3; i++) begin
      sb.push_back(model(av[i], bv[i], longint'(DEF_MAX_ITER)));
      run_op(av[i], bv[i], 1'b0, 0, 0, dc, dn, bb, lc, lo, q, r, ae, oe);
      e = sb.pop_front();
      n_total++; if (dc !== e.done_cyc) $display("FAIL arg_done_cycle[%0d]: got %0d expected %0d", i, dc, e.done_cyc); else n_pass++;
      n_total++; if ({ae, oe} !== {e.ae, e.oe}) $display("FAIL arg_flags[%0d]: got %b expected %b", i, {ae, oe}, {e.ae, e.oe}); else n_pass++;
      n_total++; if (lc !== e.lds) $display("FAIL arg_no_load[%0d]: got %0d expected %0d", i, lc, e.lds); else n_pass++;
    end
  endtask

  task automatic test_watchdog();
    logic [31:0] av [4] = '{32'd1000, 32'd100, 32'd11, 32'd5};
    logic [31:0] bv [4] = '{32'd1, 32'd10, 32'd1, 32'd9};
    int dc, dn, bb, lc, lo; logic [31:0] q, r; logic ae, oe; exp_t e;
    for (int i = 0; i < 4; i++) begin
      sb.push_back(model(av[i], bv[i], 64'd10));
      run_op(av[i], bv[i], 1'b1, 0, 0, dc, dn, bb, lc, lo, q, r, ae, oe);
      e = sb.pop_front();
      n_total++; if (dc !== e.done_cyc) $display("FAIL wd_done_cycle[%0d]: got %0d expected %0d", i, dc, e.done_cyc); else n_pass++;
      n_total++; if (q !== e.q || r !== e.r) $display("FAIL wd_result[%0d]: got q=%0d r=%0d expected q=%0d r=%0d", i, q, r, e.q, e.r); else n_pass++;
      n_total++; if ({ae, oe} !== {e.ae, e.oe}) $display("FAIL wd_flags[%0d]: got %b expected %b", i, {ae, oe}, {e.ae, e.oe}); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    int dc, dn, bb, lc, lo; logic [31:0] q, r; logic ae, oe; exp_t e;
    sb.push_back(model(32'd100, 32'd7, longint'(DEF_MAX_ITER)));
    run_op(32'd100, 32'd7, 1'b0, 5, 17, dc, dn, bb, lc, lo, q, r, ae, oe);
    e = sb.pop_front();
    n_total++; if (dn !== 1) $display("FAIL b2b_single_done: got %0d pulses expected 1", dn); else n_pass++;
    n_total++; if (dc !== e.done_cyc) $display("FAIL b2b_done_cycle: got %0d expected %0d", dc, e.done_cyc); else n_pass++;
    n_total++; if (q !== e.q || r !== e.r) $display("FAIL b2b_result: got q=%0d r=%0d expected q=%0d r=%0d", q, r, e.q, e.r); else n_pass++;
    n_total++; if (bb !== 0) $display("FAIL b2b_busy: got %0d bad cycles expected 0", bb); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int dc, dn, bb, lc, lo, seen; logic [31:0] q, r; logic ae, oe; exp_t e;
    @(negedge clk);
    m_if.A = 32'd100; m_if.B = 32'd7; m_if.start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      m_if.start = 1'b0;
    end
    n_total++; if (m_if.busy !== 1'b1) $display("FAIL mid_busy_before: got %b expected 1", m_if.busy); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({m_if.busy, m_if.done, ld_m, mux_m, m_if.arg_err, m_if.ovf_err} !== 6'b0) begin
      $display("FAIL mid_reset_outputs: got %b expected 000000",
               {m_if.busy, m_if.done, ld_m, mux_m, m_if.arg_err, m_if.ovf_err});
    end else n_pass++;
    seen = 0;
    repeat (3) begin @(negedge clk); if (m_if.done) seen++; end
    rst_n = 1'b1;
    repeat (20) begin @(negedge clk); if (m_if.done || m_if.busy) seen++; end
    n_total++; if (seen !== 0) $display("FAIL mid_no_done: got %0d active cycles expected 0", seen); else n_pass++;
    sb.push_back(model(32'd100, 32'd7, longint'(DEF_MAX_ITER)));
    run_op(32'd100, 32'd7, 1'b0, 0, 0, dc, dn, bb, lc, lo, q, r, ae, oe);
    e = sb.pop_front();
    n_total++; if (q !== e.q || r !== e.r || dc !== e.done_cyc) $display("FAIL mid_fresh_run: got q=%0d r=%0d cyc=%0d expected q=%0d r=%0d cyc=%0d", q, r, dc, e.q, e.r, e.done_cyc); else n_pass++;
  endtask

  initial begin
    m_if.start = 1'b0; m_if.A = 32'd0; m_if.B = 32'd1;
    w_if.start = 1'b0; w_if.A = 32'd0; w_if.B = 32'd1;
    test_reset();
    test_basic();
    test_arg_err();
    test_short();
    test_watchdog();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
